// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the loader, instruction fetch
// and data requesters. Each grant runs a fixed IDLE -> ISSUE -> RESP transaction.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    output logic [DW-1:0] ld_rdata,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    grant,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_LD   = 2'b01;
    localparam logic [1:0] GNT_IF   = 2'b10;
    localparam logic [1:0] GNT_DM   = 2'b11;

    state_t          r_state;
    state_t          w_nextState;
    logic [1:0]      r_grant;
    logic [1:0]      w_winner;
    logic            r_rr;
    logic            r_ldAck;
    logic            r_ifAck;
    logic            r_dmAck;
    logic [DW-1:0]   r_ldRdata;
    logic [DW-1:0]   r_ifRdata;
    logic [DW-1:0]   r_dmRdata;
    logic            r_memWe;
    logic [AW-1:0]   r_memAddr;
    logic [DW-1:0]   r_memWdata;
    logic            w_ldElig;
    logic            w_ifElig;
    logic            w_dmElig;
    logic [AW-1:0]   w_selAddr;
    logic            w_selWe;
    logic [DW-1:0]   w_selWdata;

    // A port whose ack is showing this cycle sits out, so a requester dropping req is not re-granted.
    assign w_ldElig = ld_req & ~r_ldAck;
    assign w_ifElig = if_req & ~r_ifAck;
    assign w_dmElig = dm_req & ~r_dmAck;

    always_comb begin
        w_winner = GNT_NONE;
        if (w_ldElig) begin
            w_winner = GNT_LD;
        end else if (w_ifElig && w_dmElig) begin
            w_winner = r_rr ? GNT_DM : GNT_IF;
        end else if (w_ifElig) begin
            w_winner = GNT_IF;
        end else if (w_dmElig) begin
            w_winner = GNT_DM;
        end
    end

    always_comb begin
        w_selAddr  = '0;
        w_selWe    = 1'b0;
        w_selWdata = '0;
        case (w_winner)
            GNT_LD: begin
                w_selAddr  = ld_addr;
                w_selWe    = ld_we;
                w_selWdata = ld_wdata;
            end
            GNT_IF: begin
                w_selAddr  = if_addr;
            end
            GNT_DM: begin
                w_selAddr  = dm_addr;
                w_selWe    = dm_we;
                w_selWdata = dm_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_winner != GNT_NONE) w_nextState = ISSUE;
            ISSUE:   w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Payload is latched only at grant; read data lands in RESP, one cycle after the strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_grant    <= GNT_NONE;
            r_rr       <= 1'b0;
            r_ldAck    <= 1'b0;
            r_ifAck    <= 1'b0;
            r_dmAck    <= 1'b0;
            r_ldRdata  <= '0;
            r_ifRdata  <= '0;
            r_dmRdata  <= '0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end else begin
            r_ldAck <= 1'b0;
            r_ifAck <= 1'b0;
            r_dmAck <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_winner != GNT_NONE) begin
                        r_grant    <= w_winner;
                        r_memAddr  <= w_selAddr;
                        r_memWe    <= w_selWe;
                        r_memWdata <= w_selWdata;
                    end
                end
                RESP: begin
                    case (r_grant)
                        GNT_LD: begin
                            r_ldAck <= 1'b1;
                            if (!r_memWe) r_ldRdata <= mem_rdata;
                        end
                        GNT_IF: begin
                            r_ifAck <= 1'b1;
                            if (!r_memWe) r_ifRdata <= mem_rdata;
                            r_rr    <= 1'b1;
                        end
                        GNT_DM: begin
                            r_dmAck <= 1'b1;
                            if (!r_memWe) r_dmRdata <= mem_rdata;
                            r_rr    <= 1'b0;
                        end
                        default: ;
                    endcase
                    r_grant <= GNT_NONE;
                end
                default: ;
            endcase
        end
    end

    assign mem_en    = (r_state == ISSUE);
    assign busy      = (r_state != IDLE);
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign grant     = r_grant;
    assign ld_ack    = r_ldAck;
    assign if_ack    = r_ifAck;
    assign dm_ack    = r_dmAck;
    assign ld_rdata  = r_ldRdata;
    assign if_rdata  = r_ifRdata;
    assign dm_rdata  = r_dmRdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a small memory model, a timeline-based reference of
// each transaction, directed scenarios with literal expectations, then random traffic.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ld_req, ld_we, if_req, dm_req, dm_we;
    logic [AW-1:0] ld_addr, if_addr, dm_addr;
    logic [DW-1:0] ld_wdata, dm_wdata;
    logic          ld_ack, if_ack, dm_ack;
    logic [DW-1:0] ld_rdata, if_rdata, dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    grant;
    logic          busy;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
    );

    // Synchronous memory: read data appears the cycle after the strobe, garbage otherwise.
    logic [31:0] envMem [0:255] = '{default: 32'h0};
    always @(posedge CLK) begin
        if (mem_en && mem_we) envMem[mem_addr[7:0]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= envMem[mem_addr[7:0]];
        else                   mem_rdata <= $urandom;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each transaction is a grant at cycle g; strobe at g+1, busy g+1..g+2, ack at g+3.
    logic [31:0] modelMem [0:255] = '{default: 32'h0};
    int          cyc = 0;
    int          gCyc = 0;
    bit          act = 1'b0;
    int          own = 0;
    bit          mWe = 1'b0;
    logic [31:0] mAddr = '0, mWdata = '0, mRdPend = '0;
    bit          mRr = 1'b0;
    logic [31:0] mRdata [1:3] = '{default: 32'h0};
    bit          expMemEn = 1'b0, expBusy = 1'b0;
    int          expGrant = 0;
    bit          expAck [1:3] = '{default: 1'b0};
    bit          modelReady = 1'b0;

    always @(posedge CLK) begin
        int old;
        int win;
        bit idleNow;
        bit ackNow [1:3];
        old = cyc;
        if (RST) begin
            act = 1'b0;
            mRr = 1'b0;
            for (int p = 1; p <= 3; p++) mRdata[p] = 32'h0;
        end else begin
            idleNow = !act || (old >= gCyc + 3);
            for (int p = 1; p <= 3; p++) ackNow[p] = act && (old == gCyc + 3) && (own == p);
            if (idleNow) begin
                win = 0;
                if (ld_req && !ackNow[1])                             win = 1;
                else if (if_req && !ackNow[2] && dm_req && !ackNow[3]) win = mRr ? 3 : 2;
                else if (if_req && !ackNow[2])                        win = 2;
                else if (dm_req && !ackNow[3])                        win = 3;
                if (win != 0) begin
                    act  = 1'b1;
                    gCyc = old;
                    own  = win;
                    case (win)
                        1: begin mAddr = ld_addr; mWe = ld_we; mWdata = ld_wdata; end
                        2: begin mAddr = if_addr; mWe = 1'b0;  mWdata = 32'h0;    end
                        default: begin mAddr = dm_addr; mWe = dm_we; mWdata = dm_wdata; end
                    endcase
                    if (mWe) modelMem[mAddr[7:0]] = mWdata;
                    else     mRdPend = modelMem[mAddr[7:0]];
                end
            end
        end
        cyc = old + 1;
        if (act && cyc == gCyc + 3) begin
            if (!mWe) mRdata[own] = mRdPend;
            if (own == 2)      mRr = 1'b1;
            else if (own == 3) mRr = 1'b0;
        end
        expMemEn = act && (cyc == gCyc + 1);
        expBusy  = act && ((cyc == gCyc + 1) || (cyc == gCyc + 2));
        expGrant = expBusy ? own : 0;
        for (int p = 1; p <= 3; p++) expAck[p] = act && (cyc == gCyc + 3) && (own == p);
        modelReady = 1'b1;
    end

    always @(negedge CLK) begin
        if (modelReady) begin
            checkOutput("grant",    {30'h0, grant}, expGrant);
            checkOutput("busy",     {31'h0, busy},  {31'h0, expBusy});
            checkOutput("mem_en",   {31'h0, mem_en}, {31'h0, expMemEn});
            checkOutput("ld_ack",   {31'h0, ld_ack}, {31'h0, expAck[1]});
            checkOutput("if_ack",   {31'h0, if_ack}, {31'h0, expAck[2]});
            checkOutput("dm_ack",   {31'h0, dm_ack}, {31'h0, expAck[3]});
            checkOutput("ld_rdata", ld_rdata, mRdata[1]);
            checkOutput("if_rdata", if_rdata, mRdata[2]);
            checkOutput("dm_rdata", dm_rdata, mRdata[3]);
            if (expMemEn) begin
                checkOutput("mem_addr", mem_addr, mAddr);
                checkOutput("mem_we",   {31'h0, mem_we}, {31'h0, mWe});
                if (mWe) checkOutput("mem_wdata", mem_wdata, mWdata);
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic clearReqs();
        ld_req = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    endtask

    task automatic applyReset();
        clearReqs();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    // One negedge worth of random requester behaviour; requesters hold req until ack.
    task automatic applyStimulus();
        if (RST) begin
            RST = 1'b0;
        end else if ($urandom_range(0, 399) == 0) begin
            RST = 1'b1;
            clearReqs();
            return;
        end
        if (ld_req && ld_ack) begin
            ld_req = $urandom_range(0, 3) == 0;
            ld_we = $urandom_range(0, 1) == 1; ld_addr = $urandom_range(0, 255); ld_wdata = $urandom;
        end else if (!ld_req && $urandom_range(0, 11) == 0) begin
            ld_req = 1'b1;
            ld_we = $urandom_range(0, 1) == 1; ld_addr = $urandom_range(0, 255); ld_wdata = $urandom;
        end
        if (if_req && if_ack) begin
            if_req = $urandom_range(0, 1) == 1; if_addr = $urandom_range(0, 255);
        end else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = $urandom_range(0, 255);
        end
        if (dm_req && dm_ack) begin
            dm_req = $urandom_range(0, 1) == 1;
            dm_we = $urandom_range(0, 1) == 1; dm_addr = $urandom_range(0, 255); dm_wdata = $urandom;
        end else if (!dm_req && $urandom_range(0, 2) == 0) begin
            dm_req = 1'b1;
            dm_we = $urandom_range(0, 1) == 1; dm_addr = $urandom_range(0, 255); dm_wdata = $urandom;
        end
    endtask

    initial begin
        RST = 1'b1;
        clearReqs();
        ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; if_addr = '0;
        dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (2) tick();
        RST = 1'b0;

        // Reset then idle
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("rst grant", {30'h0, grant}, 32'h0);
            checkOutput("rst busy", {31'h0, busy}, 32'h0);
            checkOutput("rst mem_en", {31'h0, mem_en}, 32'h0);
            checkOutput("rst mem_we", {31'h0, mem_we}, 32'h0);
            checkOutput("rst mem_addr", mem_addr, 32'h0);
            checkOutput("rst mem_wdata", mem_wdata, 32'h0);
            checkOutput("rst acks", {29'h0, ld_ack, if_ack, dm_ack}, 32'h0);
            checkOutput("rst rdata", ld_rdata | if_rdata | dm_rdata, 32'h0);
        end

        // Loader write then fetch read of the same word
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h0; ld_wdata = 32'h2000_0001;
        tick();
        checkOutput("t2 ld grant", {30'h0, grant}, 32'h1);
        checkOutput("t2 mem_en", {31'h0, mem_en}, 32'h1);
        checkOutput("t2 mem_we", {31'h0, mem_we}, 32'h1);
        checkOutput("t2 mem_wdata", mem_wdata, 32'h2000_0001);
        tick();
        checkOutput("t2 resp mem_en", {31'h0, mem_en}, 32'h0);
        tick();
        checkOutput("t2 ld_ack", {31'h0, ld_ack}, 32'h1);
        checkOutput("t2 ack busy", {31'h0, busy}, 32'h0);
        ld_req = 1'b0;
        if_req = 1'b1; if_addr = 32'h0;
        tick();
        checkOutput("t2 if grant", {30'h0, grant}, 32'h2);
        checkOutput("t2 if mem_we", {31'h0, mem_we}, 32'h0);
        tick(); tick();
        checkOutput("t2 if_ack", {31'h0, if_ack}, 32'h1);
        checkOutput("t2 if_rdata", if_rdata, 32'h2000_0001);
        if_req = 1'b0;

        // Simultaneous fetch and data from reset
        applyReset();
        if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0;
        tick();
        checkOutput("t3 first grant", {30'h0, grant}, 32'h2);
        tick(); tick();
        checkOutput("t3 if_ack", {31'h0, if_ack}, 32'h1);
        if_req = 1'b0;
        tick();
        checkOutput("t3 second grant", {30'h0, grant}, 32'h3);
        tick(); tick();
        checkOutput("t3 dm_ack", {31'h0, dm_ack}, 32'h1);
        checkOutput("t3 dm_rdata", dm_rdata, 32'h2000_0001);
        dm_req = 1'b0;
        if_req = 1'b1;
        tick();
        checkOutput("t3 lone fetch", {30'h0, grant}, 32'h2);
        tick(); tick();
        if_req = 1'b0;
        tick();
        if_req = 1'b1; dm_req = 1'b1;
        tick();
        checkOutput("t3 repeat data first", {30'h0, grant}, 32'h3);
        tick(); tick();
        dm_req = 1'b0;
        tick();
        checkOutput("t3 repeat fetch next", {30'h0, grant}, 32'h2);
        tick(); tick();
        if_req = 1'b0;
        tick();

        // All three together
        applyReset();
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0;
        tick();
        checkOutput("t4 grant ld", {30'h0, grant}, 32'h1);
        tick(); tick();
        checkOutput("t4 ld_ack", {31'h0, ld_ack}, 32'h1);
        tick();
        checkOutput("t4 no ld regrant", {30'h0, grant}, 32'h2);
        ld_req = 1'b0;
        tick(); tick();
        if_req = 1'b0;
        tick();
        checkOutput("t4 grant dm", {30'h0, grant}, 32'h3);
        tick(); tick();
        checkOutput("t4 dm_rdata", dm_rdata, 32'h2000_0001);
        dm_req = 1'b0;
        tick();

        // Data write then read back, rdata untouched by the write
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        tick();
        checkOutput("t5 wr mem_addr", mem_addr, 32'h40);
        checkOutput("t5 wr mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick(); tick();
        checkOutput("t5 wr dm_ack", {31'h0, dm_ack}, 32'h1);
        checkOutput("t5 rdata kept", dm_rdata, 32'h2000_0001);
        dm_we = 1'b0;
        tick();
        checkOutput("t5 blocked regrant", {30'h0, grant}, 32'h0);
        tick();
        checkOutput("t5 rd grant", {30'h0, grant}, 32'h3);
        tick(); tick();
        checkOutput("t5 rd dm_ack", {31'h0, dm_ack}, 32'h1);
        checkOutput("t5 rd dm_rdata", dm_rdata, 32'hDEAD_BEEF);
        dm_req = 1'b0;
        tick();

        // Reset during RESP of a fetch
        if_req = 1'b1; if_addr = 32'h40;
        tick();
        tick();
        checkOutput("t6 in resp", {31'h0, busy}, 32'h1);
        RST = 1'b1;
        tick();
        checkOutput("t6 no if_ack", {31'h0, if_ack}, 32'h0);
        checkOutput("t6 if_rdata", if_rdata, 32'h0);
        checkOutput("t6 idle", {31'h0, busy}, 32'h0);
        checkOutput("t6 mem_en", {31'h0, mem_en}, 32'h0);
        RST = 1'b0;
        if_req = 1'b0;
        tick();
        checkOutput("t6 still no ack", {31'h0, if_ack}, 32'h0);

        // Random traffic against the reference
        for (int i = 0; i < 4000; i++) begin
            applyStimulus();
            tick();
        end
        RST = 1'b0;
        clearReqs();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
